// File: rtl/reset_seq_pkg.sv
// Shared state encoding and counter sizing for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// PLL/software inputs and per-domain reset outputs of the reset sequencer.
interface reset_sequencer_if #(
  parameter int CHANNELS = 4
);
  logic                iPLL_LOCKED;
  logic                iSW_RESET;
  logic [CHANNELS-1:0] oRESETn;
  logic                oREADY;
  logic [1:0]          oSTATE;

  modport slave (
    input  iPLL_LOCKED,
    input  iSW_RESET,
    output oRESETn,
    output oREADY,
    output oSTATE
  );

  modport master (
    output iPLL_LOCKED,
    output iSW_RESET,
    input  oRESETn,
    input  oREADY,
    input  oSTATE
  );
endinterface

// File: rtl/reset_seq_timer.sv
// Saturating up-counter with clear and enable; o_last flags the edge that reaches TARGET.
module reset_seq_timer
  import reset_seq_pkg::*;
#(
  parameter int TARGET = 8
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);
  localparam int W = cnt_w(TARGET);
  localparam logic [W-1:0] MAX  = W'(TARGET);
  localparam logic [W-1:0] LAST = W'(TARGET - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // Independent of i_clr so the caller may clear on the very edge this fires.
  assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/reset_sequencer.sv
// Qualifies PLL lock, holds all domain resets, then releases them one by one in index order.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 32,
  parameter int STAGE_GAP   = 8
) (
  input  logic               iCLK,
  input  logic               iRESETn,
  reset_sequencer_if.slave   bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] PENULT = CW'((CHANNELS > 1) ? CHANNELS - 2 : 0);

  state_t              r_state, w_state_nx;
  logic [CHANNELS-1:0] r_resetn, w_resetn_nx;
  logic                r_ready, w_ready_nx;
  logic [CW-1:0]       r_chan, w_chan_nx;

  logic w_abort;
  logic w_hold_en, w_hold_clr, w_hold_last;
  logic w_stage_en, w_stage_clr, w_stage_last;

  assign w_abort = !bus.iPLL_LOCKED || bus.iSW_RESET;

  reset_seq_timer #(.TARGET(HOLD_CYCLES)) u_hold (
    .i_clk  (iCLK),
    .i_rstn (iRESETn),
    .i_clr  (w_hold_clr),
    .i_en   (w_hold_en),
    .o_last (w_hold_last)
  );

  reset_seq_timer #(.TARGET(STAGE_GAP)) u_stage (
    .i_clk  (iCLK),
    .i_rstn (iRESETn),
    .i_clr  (w_stage_clr),
    .i_en   (w_stage_en),
    .o_last (w_stage_last)
  );

  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      r_state  <= ST_WAIT;
      r_resetn <= '0;
      r_ready  <= 1'b0;
      r_chan   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_resetn <= w_resetn_nx;
      r_ready  <= w_ready_nx;
      r_chan   <= w_chan_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_resetn_nx = r_resetn;
    w_ready_nx  = r_ready;
    w_chan_nx   = r_chan;
    w_hold_en   = 1'b0;
    w_hold_clr  = 1'b0;
    w_stage_en  = 1'b0;
    w_stage_clr = 1'b0;

    if (w_abort) begin
      w_state_nx  = ST_WAIT;
      w_resetn_nx = '0;
      w_ready_nx  = 1'b0;
      w_chan_nx   = '0;
      w_hold_clr  = 1'b1;
      w_stage_clr = 1'b1;
    end else begin
      case (r_state)
        ST_WAIT: begin
          w_hold_en = 1'b1;
          if (w_hold_last) begin
            w_hold_clr  = 1'b1;
            w_stage_clr = 1'b1;
            w_resetn_nx = CHANNELS'(1);
            w_chan_nx   = '0;
            if (CHANNELS == 1) begin
              w_state_nx = ST_RUN;
              w_ready_nx = 1'b1;
            end else begin
              w_state_nx = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          w_stage_en = 1'b1;
          if (w_stage_last) begin
            // Shifting a 1 in from the bottom keeps the outputs thermometer-coded.
            w_stage_clr = 1'b1;
            w_resetn_nx = (r_resetn << 1) | CHANNELS'(1);
            w_chan_nx   = r_chan + CW'(1);
            if (r_chan == PENULT) begin
              w_state_nx = ST_RUN;
              w_ready_nx = 1'b1;
            end
          end
        end
        ST_RUN: begin
          w_state_nx = ST_RUN;
        end
        default: begin
          w_state_nx  = ST_WAIT;
          w_resetn_nx = '0;
          w_ready_nx  = 1'b0;
          w_chan_nx   = '0;
          w_hold_clr  = 1'b1;
          w_stage_clr = 1'b1;
        end
      endcase
    end
  end

  assign bus.oRESETn = r_resetn;
  assign bus.oREADY  = r_ready;
  assign bus.oSTATE  = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default build plus a single-channel build, directed table and random stimulus.
module tb_reset_sequencer;

  logic clk;
  logic rstn_a, rstn_b;
  int   checks, errors;
  int   ga, gb;

  reset_sequencer_if #(.CHANNELS(4)) ifa ();
  reset_sequencer_if #(.CHANNELS(1)) ifb ();

  reset_sequencer #(.CHANNELS(4), .HOLD_CYCLES(32), .STAGE_GAP(8)) dut_a (
    .iCLK    (clk),
    .iRESETn (rstn_a),
    .bus     (ifa)
  );

  reset_sequencer #(.CHANNELS(1), .HOLD_CYCLES(1), .STAGE_GAP(1)) dut_b (
    .iCLK    (clk),
    .iRESETn (rstn_b),
    .bus     (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       rstn;
    logic       lock;
    logic       sw;
    logic [3:0] er;
    logic       erdy;
    logic [1:0] est;
  } vec_t;

  vec_t tbl [30];

  // Channels released after g consecutive clean edges.
  function automatic int released(input int g, input int ch, input int hold, input int gap);
    int n;
    if (g < hold) return 0;
    n = 1 + (g - hold) / gap;
    return (n > ch) ? ch : n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_model(input string tag, input int g, input int ch, input int hold,
                             input int gap, input int r, input int rdy, input int st);
    int n;
    n = released(g, ch, hold, gap);
    chk({tag, "_resetn"}, r, (1 << n) - 1);
    chk({tag, "_ready"}, rdy, (n == ch) ? 1 : 0);
    chk({tag, "_state"}, st, (n == 0) ? 0 : ((n < ch) ? 1 : 2));
    chk({tag, "_therm"}, ((r & (r + 1)) == 0) ? 1 : 0, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rstn_a || !ifa.iPLL_LOCKED || ifa.iSW_RESET) ga = 0;
    else if (ga < 1000000) ga++;
    if (!rstn_b || !ifb.iPLL_LOCKED || ifb.iSW_RESET) gb = 0;
    else if (gb < 1000000) gb++;
    #1;
    check_model("A", ga, 4, 32, 8, int'(ifa.oRESETn), int'(ifa.oREADY), int'(ifa.oSTATE));
    check_model("B", gb, 1, 1, 1, int'(ifb.oRESETn), int'(ifb.oREADY), int'(ifb.oSTATE));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ga = 0;
    gb = 0;
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    ifa.iPLL_LOCKED = 1'b1;
    ifa.iSW_RESET   = 1'b0;
    ifb.iPLL_LOCKED = 1'b1;
    ifb.iSW_RESET   = 1'b0;

    tbl[0]  = '{5,  1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{31, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[2]  = '{1,  1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd1};
    tbl[3]  = '{7,  1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd1};
    tbl[4]  = '{1,  1'b1, 1'b1, 1'b0, 4'b0011, 1'b0, 2'd1};
    tbl[5]  = '{8,  1'b1, 1'b1, 1'b0, 4'b0111, 1'b0, 2'd1};
    tbl[6]  = '{7,  1'b1, 1'b1, 1'b0, 4'b0111, 1'b0, 2'd1};
    tbl[7]  = '{1,  1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd2};
    tbl[8]  = '{10, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd2};
    tbl[9]  = '{1,  1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[10] = '{55, 1'b1, 1'b1, 1'b0, 4'b0111, 1'b0, 2'd1};
    tbl[11] = '{1,  1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd2};
    tbl[12] = '{1,  1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[13] = '{55, 1'b1, 1'b1, 1'b0, 4'b0111, 1'b0, 2'd1};
    tbl[14] = '{1,  1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd2};
    tbl[15] = '{1,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[16] = '{20, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[17] = '{1,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[18] = '{31, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[19] = '{1,  1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd1};
    tbl[20] = '{1,  1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[21] = '{43, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b0, 2'd1};
    tbl[22] = '{1,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[23] = '{31, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[24] = '{1,  1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd1};
    tbl[25] = '{24, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd2};
    tbl[26] = '{1,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[27] = '{45, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b0, 2'd1};
    tbl[28] = '{1,  1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[29] = '{56, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd2};

    rstn_b = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rstn_a          = tbl[i].rstn;
      ifa.iPLL_LOCKED = tbl[i].lock;
      ifa.iSW_RESET   = tbl[i].sw;
      repeat (tbl[i].n) tick();
      chk($sformatf("tbl%0d_resetn", i), int'(ifa.oRESETn), int'(tbl[i].er));
      chk($sformatf("tbl%0d_ready", i), int'(ifa.oREADY), int'(tbl[i].erdy));
      chk($sformatf("tbl%0d_state", i), int'(ifa.oSTATE), int'(tbl[i].est));
    end

    // Single-channel build: release and RUN on the first clean edge.
    rstn_b = 1'b0;
    repeat (2) tick();
    chk("b_rst_resetn", int'(ifb.oRESETn), 0);
    chk("b_rst_state", int'(ifb.oSTATE), 0);
    rstn_b = 1'b1;
    tick();
    chk("b_edge1_resetn", int'(ifb.oRESETn), 1);
    chk("b_edge1_ready", int'(ifb.oREADY), 1);
    chk("b_edge1_state", int'(ifb.oSTATE), 2);
    ifb.iPLL_LOCKED = 1'b0;
    tick();
    chk("b_abort_resetn", int'(ifb.oRESETn), 0);
    chk("b_abort_state", int'(ifb.oSTATE), 0);
    ifb.iPLL_LOCKED = 1'b1;
    tick();
    chk("b_rerun_state", int'(ifb.oSTATE), 2);

    // Random stimulus against the arithmetic model.
    for (int i = 0; i < 4000; i++) begin
      rstn_a          = ($urandom_range(0, 199) != 0);
      ifa.iPLL_LOCKED = ($urandom_range(0, 99) != 0);
      ifa.iSW_RESET   = ($urandom_range(0, 149) == 0);
      rstn_b          = ($urandom_range(0, 9) != 0);
      ifb.iPLL_LOCKED = ($urandom_range(0, 3) != 0);
      ifb.iSW_RESET   = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
